// File: rtl/d_mem_bus_initiator.sv
// MEM-stage initiator for a multi-cycle req/ack data-memory bus (one transaction in flight).
// Optional: define MEM_ALIGN_CHECK_EN to abort misaligned accesses without a bus cycle.
module d_mem_bus_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic [DATA_W-1:0] read_data,
  output logic              load_valid,
  output logic              bus_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              lv_q, lv_d;
  logic              err_q, err_d;

  logic req_in;
  logic misalign;

  assign req_in = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (address[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lv_d    = lv_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        lv_d  = 1'b0;
        err_d = 1'b0;
        cnt_d = '0;
        if (req_in) begin
          if (misalign) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            // a store wins when both strobes are set
            state_d = S_BUSY;
            we_d    = MemWrite;
            addr_d  = address;
            wdata_d = write_data;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = bus_rdata;
            lv_d    = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        lv_d    = 1'b0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        lv_d    = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lv_q    <= lv_d;
      err_q   <= err_d;
    end
  end

  // bus_req decodes straight from state so reset drops it immediately
  assign bus_req    = (state_q == S_BUSY);
  assign stall      = bus_req | ((state_q == S_IDLE) & req_in);
  assign load_valid = (state_q == S_DONE) & lv_q;
  assign bus_error  = (state_q == S_DONE) & err_q;
  assign read_data  = rdata_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;

endmodule
